// File: rtl/apple_video_serializer_if.sv
// Parallel video byte bus from the aux slot and the serial dot / line timing
// outputs toward the scan-converter.
interface apple_video_serializer_if #(
   parameter int HCOUNT_WIDTH = 10
);
   logic [7:0]              vid;
   logic                    ldps_n;
   logic                    vid7m;
   logic                    gr;
   logic                    sync_n;
   logic                    pix;
   logic                    active;
   logic [HCOUNT_WIDTH-1:0] hcount;
   logic                    line_start;
   logic                    underrun;

   modport master (
      output vid, ldps_n, vid7m, gr, sync_n,
      input  pix, active, hcount, line_start, underrun
   );

   modport slave (
      input  vid, ldps_n, vid7m, gr, sync_n,
      output pix, active, hcount, line_start, underrun
   );
endinterface

// File: rtl/apple_video_serializer.sv
// IIe-style video shift register: parallel byte load, 7M/14M dot rate,
// hi-res half-dot delay, plus per-line dot position and underrun pulse.
module apple_video_serializer #(
   parameter int DOTS_PER_LOAD = 7,
   parameter int HCOUNT_WIDTH  = 10
) (
   input logic                      clk_14M,
   input logic                      reset_n,
   apple_video_serializer_if.slave  vif
);
   localparam int CW = $clog2(DOTS_PER_LOAD + 1);
   localparam logic [CW-1:0]           LOAD_CNT = CW'(DOTS_PER_LOAD);
   localparam logic [CW-1:0]           ONE_CNT  = CW'(1);
   localparam logic [HCOUNT_WIDTH-1:0] HC_MAX   = '1;

   logic [DOTS_PER_LOAD-1:0] r_shift;
   logic [CW-1:0]            r_cnt;
   logic                     r_phase;
   logic                     r_dly;
   logic                     r_pix_d1;
   logic                     r_underrun;
   logic                     r_active;
   logic                     r_line_start;
   logic [HCOUNT_WIDTH-1:0]  r_hcount;
   logic                     w_dot_en;
   logic                     w_rise;

   assign w_dot_en = ~vif.vid7m | r_phase;
   assign w_rise   = ~r_active & vif.sync_n;

   // r_cnt counts the dot on the output too: 1 means the byte is exhausted,
   // 0 means nothing has been loaded since reset, so no underrun is reported.
   always_ff @(posedge clk_14M or negedge reset_n) begin
      if (!reset_n) begin
         r_shift    <= '0;
         r_cnt      <= '0;
         r_phase    <= 1'b0;
         r_dly      <= 1'b0;
         r_pix_d1   <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_pix_d1   <= r_shift[0];
         r_underrun <= 1'b0;
         if (!vif.ldps_n) begin
            r_shift <= vif.vid[DOTS_PER_LOAD-1:0];
            r_cnt   <= LOAD_CNT;
            r_dly   <= vif.gr & vif.vid[7];
            r_phase <= 1'b0;
         end else begin
            r_phase <= ~r_phase;
            if (w_dot_en) begin
               r_shift <= {1'b0, r_shift[DOTS_PER_LOAD-1:1]};
               if (r_cnt > ONE_CNT)
                  r_cnt <= r_cnt - ONE_CNT;
               else if (r_cnt == ONE_CNT)
                  r_underrun <= r_active;
            end
         end
      end
   end

   // hcount only advances while the next cycle stays active, so it holds
   // the last active position through blanking.
   always_ff @(posedge clk_14M or negedge reset_n) begin
      if (!reset_n) begin
         r_active     <= 1'b0;
         r_line_start <= 1'b0;
         r_hcount     <= '0;
      end else begin
         r_active     <= vif.sync_n;
         r_line_start <= w_rise;
         if (w_rise)
            r_hcount <= '0;
         else if (r_active && vif.sync_n && r_hcount != HC_MAX)
            r_hcount <= r_hcount + 1'b1;
      end
   end

   assign vif.pix        = r_active & (r_dly ? r_pix_d1 : r_shift[0]);
   assign vif.active     = r_active;
   assign vif.hcount     = r_hcount;
   assign vif.line_start = r_line_start;
   assign vif.underrun   = r_underrun;
endmodule

// File: tb/tb_apple_video_serializer.sv
// Randomized bench for apple_video_serializer against a dot-timeline model.
module tb_apple_video_serializer;
   logic clk_14M = 1'b0;
   logic reset_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   apple_video_serializer_if #(.HCOUNT_WIDTH(10)) vif ();

   apple_video_serializer #(.DOTS_PER_LOAD(7), .HCOUNT_WIDTH(10)) dut (
      .clk_14M (clk_14M),
      .reset_n (reset_n),
      .vif     (vif)
   );

   always #5 clk_14M = ~clk_14M;

   // Dot shown t cycles after the load edge: dot n occupies one cycle (14M)
   // or two (7M); the delay flag pushes the whole timeline one cycle later.
   function automatic logic exp_pix(input logic [7:0] b, input logic m,
                                    input logic d, input int t);
      int u;
      int n;
      u = d ? t - 1 : t;
      if (u < 1) return 1'b0;
      n = m ? (u - 1) / 2 : u - 1;
      if (n >= 7) return 1'b0;
      return b[n];
   endfunction

   // Dot 7 would be due at t=8 (14M) or t=15 (7M); every later due dot starves.
   function automatic logic exp_und(input logic m, input int t);
      if (m) return (t >= 15) && (t % 2 == 1);
      return t >= 8;
   endfunction

   task automatic tick();
      @(posedge clk_14M);
      #1;
   endtask

   task automatic run_byte(input logic [7:0] b, input logic m, input logic g,
                           input int ncyc, input string name);
      logic d;
      d = g & b[7];
      vif.vid    = b;
      vif.vid7m  = m;
      vif.gr     = g;
      vif.ldps_n = 1'b0;
      tick();
      vif.ldps_n = 1'b1;
      vif.vid    = 8'($urandom);
      for (int t = 1; t <= ncyc; t++) begin
         vectors++;
         if (vif.pix !== exp_pix(b, m, d, t)) begin
            miscompares++;
            $display("FAIL %s pix b=%h m=%0d g=%0d t=%0d got=%b exp=%b",
                     name, b, m, g, t, vif.pix, exp_pix(b, m, d, t));
         end
         vectors++;
         if (vif.underrun !== exp_und(m, t)) begin
            miscompares++;
            $display("FAIL %s underrun b=%h m=%0d t=%0d got=%b exp=%b",
                     name, b, m, t, vif.underrun, exp_und(m, t));
         end
         if (t < ncyc) tick();
      end
   endtask

   task automatic check_idle(input string name, input logic [9:0] hc);
      vectors++;
      if (vif.pix !== 1'b0 || vif.active !== 1'b0 || vif.hcount !== hc ||
          vif.line_start !== 1'b0 || vif.underrun !== 1'b0) begin
         miscompares++;
         $display("FAIL %s pix=%b active=%b hcount=%0d line_start=%b underrun=%b exp hcount=%0d others 0",
                  name, vif.pix, vif.active, vif.hcount, vif.line_start, vif.underrun, hc);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         vif.vid    = 8'($urandom);
         vif.ldps_n = 1'($urandom);
         vif.vid7m  = 1'($urandom);
         vif.gr     = 1'($urandom);
         vif.sync_n = 1'($urandom);
         tick();
         check_idle("reset_hold", 10'd0);
      end
      vif.ldps_n = 1'b1;
      vif.sync_n = 1'b0;
      #3 reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_idle("reset_release", 10'd0);
      end
   endtask

   // Drives sync_n for n edges; expected hcount is derived from how many
   // edges of the current high run have elapsed.
   task automatic sync_run(input logic level, input int n, inout int hc_exp,
                           input string name);
      vif.sync_n = level;
      for (int j = 1; j <= n; j++) begin
         tick();
         if (level) hc_exp = (j - 1 > 1023) ? 1023 : j - 1;
         vectors++;
         if (vif.active !== level || vif.line_start !== (level && j == 1) ||
             vif.hcount !== 10'(hc_exp) || vif.underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL %s j=%0d active=%b/%b line_start=%b/%b hcount=%0d/%0d underrun=%b/0",
                     name, j, vif.active, level, vif.line_start, level && j == 1,
                     vif.hcount, hc_exp, vif.underrun);
         end
      end
   endtask

   task automatic test_line_timing();
      int hc;
      hc = 0;
      vif.ldps_n = 1'b1;
      sync_run(1'b0, 200, hc, "line_blank");
      sync_run(1'b1, 600, hc, "line_active");
      sync_run(1'b0, 50, hc, "line_hold599");
   endtask

   task automatic test_saturation();
      int hc;
      hc = 599;
      sync_run(1'b1, 1100, hc, "hcount_sat");
      sync_run(1'b0, 10, hc, "hold_sat");
   endtask

   task automatic test_14m();
      vif.sync_n = 1'b1;
      tick();
      tick();
      run_byte(8'h35, 1'b0, 1'b0, 18, "ser14m_35");
   endtask

   task automatic test_7m_delay();
      run_byte(8'h81, 1'b1, 1'b1, 18, "ser7m_delay");
      run_byte(8'h81, 1'b1, 1'b0, 18, "ser7m_nodelay");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++)
         run_byte((i % 2 == 0) ? 8'h7F : 8'h00, 1'b0, 1'b0, 7, "back_to_back");
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++)
         run_byte(8'($urandom), 1'($urandom), 1'($urandom), 18, "random");
   endtask

   task automatic test_mid_reset();
      vif.vid    = 8'h7F;
      vif.vid7m  = 1'b0;
      vif.gr     = 1'b0;
      vif.ldps_n = 1'b0;
      tick();
      vif.ldps_n = 1'b1;
      tick();
      tick();
      #2 reset_n = 1'b0;
      #1 check_idle("midreset_async", 10'd0);
      tick();
      check_idle("midreset_hold", 10'd0);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         vectors++;
         if (vif.underrun !== 1'b0 || vif.pix !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_after i=%0d underrun=%b pix=%b exp 0 0",
                     i, vif.underrun, vif.pix);
         end
      end
      run_byte(8'($urandom), 1'b0, 1'b0, 18, "midreset_reload");
   endtask

   initial begin
      vif.vid    = 8'h00;
      vif.ldps_n = 1'b1;
      vif.vid7m  = 1'b0;
      vif.gr     = 1'b0;
      vif.sync_n = 1'b0;
      test_reset();
      test_line_timing();
      test_saturation();
      test_14m();
      test_7m_delay();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
